hazard_scoreboard: RTL and testbench

// Parametrised hazard controller for the pipelined CPU, sitting beside the ID stage.

---
 rtl/hazard_scoreboard.sv | 185 ++++++++++++++++++
 tb/tb_hazard_scoreboard.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// ============================================================================
// hazard_scoreboard
// ----------------------------------------------------------------------------
// Hazard controller placed beside the ID stage of the pipelined CPU.
//
// A per-register countdown scoreboard tracks results that are still in flight
// from multi-cycle producers (loads and the multiply/divide unit). The block
// detects three kinds of hazard for the instruction in ID:
//   - RAW: a source register is still pending.
//   - WAW: the destination register is still pending.
//   - MDU structural: the MDU is still occupied by an earlier operation.
// A hazard holds the PC and IF/ID and inserts a bubble into ID/EX.
//
// Redirects resolved in EX kill IF/ID for a configurable number of cycles.
// A flush takes priority over a stall.
//
// Plain ALU results are forwarded elsewhere, so they never stall.
//
// Parameters
//   REG_ADDR_W  register address width; register 0 is never busy
//   NUM_SRC     source operands checked per decoded instruction
//   LOAD_LAT    cycles a load result is unavailable after issue (>=1)
//   MDU_LAT     cycles an MDU result is unavailable after issue, and also the
//               MDU occupancy (>=1)
//   FLUSH_J     IF/ID kill cycles after ex_jump
//   FLUSH_JR    IF/ID kill cycles after ex_jump_r
//
// Ports
//   clk          rising-edge clock
//   rstn         asynchronous active-low reset
//   id_valid     ID holds a valid instruction
//   id_src_addr  packed source addresses; src i at [i*REG_ADDR_W +: REG_ADDR_W]
//   id_src_used  source i is actually read
//   id_dst_addr  destination register
//   id_dst_we    instruction writes id_dst_addr
//   id_is_load   instruction is a load
//   id_is_mdu    instruction uses the multiply/divide unit
//   ex_jump      direct jump / taken branch resolved in EX this cycle
//   ex_jump_r    register jump resolved in EX this cycle
//   stall        hold PC and IF/ID
//   bubble       force a NOP into ID/EX
//   flush        kill IF/ID contents
//   busy_mask    bit r set while register r has a pending write
// ============================================================================
module hazard_scoreboard #(
  parameter int REG_ADDR_W = 5,
  parameter int NUM_SRC    = 2,
  parameter int LOAD_LAT   = 1,
  parameter int MDU_LAT    = 4,
  parameter int FLUSH_J    = 1,
  parameter int FLUSH_JR   = 2
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          id_valid,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] id_src_addr,
  input  logic [NUM_SRC-1:0]            id_src_used,
  input  logic [REG_ADDR_W-1:0]         id_dst_addr,
  input  logic                          id_dst_we,
  input  logic                          id_is_load,
  input  logic                          id_is_mdu,
  input  logic                          ex_jump,
  input  logic                          ex_jump_r,
  output logic                          stall,
  output logic                          bubble,
  output logic                          flush,
  output logic [(2**REG_ADDR_W)-1:0]    busy_mask
);

  localparam int NREG   = 2 ** REG_ADDR_W;
  localparam int MAXLAT = (LOAD_LAT > MDU_LAT) ? LOAD_LAT : MDU_LAT;
  localparam int CW     = $clog2(MAXLAT + 1);
  localparam int MW     = $clog2(MDU_LAT + 1);
  localparam int FMAX   = (FLUSH_J > FLUSH_JR) ? FLUSH_J : FLUSH_JR;
  localparam int FW     = $clog2(FMAX + 1);

  // Counters that stop at zero.
  function automatic logic [CW-1:0] dec_pend(input logic [CW-1:0] v);
    return (v != '0) ? v - CW'(1) : v;
  endfunction

  function automatic logic [MW-1:0] dec_mdu(input logic [MW-1:0] v);
    return (v != '0) ? v - MW'(1) : v;
  endfunction

  function automatic logic [FW-1:0] dec_flush(input logic [FW-1:0] v);
    return (v != '0) ? v - FW'(1) : v;
  endfunction

  logic [CW-1:0]         pend [NREG];
  logic [MW-1:0]         mdu_cnt;
  logic [FW-1:0]         flush_cnt;

  logic [REG_ADDR_W-1:0] src_addr [NUM_SRC];
  logic                  raw;
  logic                  waw;
  logic                  mdu_hz;
  logic                  dst_live;
  logic                  redirect;
  logic                  issue;
  logic [CW-1:0]         issue_lat;

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    assign src_addr[gi] = id_src_addr[gi*REG_ADDR_W +: REG_ADDR_W];
  end

  // ---- Hazard detection (combinational, same cycle as decode) ----
  always_comb begin
    raw = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (id_src_used[i] && (src_addr[i] != '0) && (pend[src_addr[i]] != '0))
        raw = 1'b1;
    end
  end

  assign dst_live = id_dst_we && (id_dst_addr != '0);
  assign waw      = dst_live && (pend[id_dst_addr] != '0);
  assign mdu_hz   = id_is_mdu && (mdu_cnt != '0);

  // A flush outranks a stall. The instruction in ID is being killed, so
  // holding it would be pointless.
  assign redirect = ex_jump || ex_jump_r;
  assign flush    = redirect || (flush_cnt != '0);
  assign stall    = id_valid && !flush && (raw || waw || mdu_hz);
  assign bubble   = flush || stall;
  assign issue    = id_valid && !stall && !flush;

  always_comb begin
    issue_lat = '0;
    if (id_is_load)
      issue_lat = CW'(LOAD_LAT);
    else if (id_is_mdu)
      issue_lat = CW'(MDU_LAT);
  end

  always_comb begin
    busy_mask = '0;
    for (int r = 0; r < NREG; r++)
      busy_mask[r] = (pend[r] != '0);
  end

  // ---- Scoreboard state update ----
  // An issuing write reloads its entry, which overrides that entry's
  // decrement. Redirects leave the scoreboard alone, because everything
  // already issued is older than the branch.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int r = 0; r < NREG; r++)
        pend[r] <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        if (r == 0)
          pend[r] <= '0;
        else if (issue && dst_live && (id_dst_addr == REG_ADDR_W'(r)))
          pend[r] <= issue_lat;
        else
          pend[r] <= dec_pend(pend[r]);
      end
    end
  end

  // An MDU operation occupies the unit even when it writes no register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      mdu_cnt <= '0;
    else if (issue && id_is_mdu)
      mdu_cnt <= MW'(MDU_LAT);
    else
      mdu_cnt <= dec_mdu(mdu_cnt);
  end

  // The redirect cycle is itself a flush cycle, so the counter is loaded
  // with one less than the kill length. A later redirect reloads it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      flush_cnt <= '0;
    else if (ex_jump_r)
      flush_cnt <= FW'(FLUSH_JR - 1);
    else if (ex_jump)
      flush_cnt <= FW'(FLUSH_J - 1);
    else
      flush_cnt <= dec_flush(flush_cnt);
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

  localparam int REG_ADDR_W = 5;
  localparam int NUM_SRC    = 2;
  localparam int LOAD_LAT   = 1;
  localparam int MDU_LAT    = 4;
  localparam int FLUSH_J    = 1;
  localparam int FLUSH_JR   = 2;
  localparam int NREG       = 2 ** REG_ADDR_W;

  logic                          clk = 1'b0;
  logic                          rstn;
  logic                          id_valid;
  logic [NUM_SRC*REG_ADDR_W-1:0] id_src_addr;
  logic [NUM_SRC-1:0]            id_src_used;
  logic [REG_ADDR_W-1:0]         id_dst_addr;
  logic                          id_dst_we;
  logic                          id_is_load;
  logic                          id_is_mdu;
  logic                          ex_jump;
  logic                          ex_jump_r;
  logic                          stall;
  logic                          bubble;
  logic                          flush;
  logic [NREG-1:0]               busy_mask;

  hazard_scoreboard #(
    .REG_ADDR_W(REG_ADDR_W), .NUM_SRC(NUM_SRC), .LOAD_LAT(LOAD_LAT),
    .MDU_LAT(MDU_LAT), .FLUSH_J(FLUSH_J), .FLUSH_JR(FLUSH_JR)
  ) dut (
    .clk(clk), .rstn(rstn), .id_valid(id_valid), .id_src_addr(id_src_addr),
    .id_src_used(id_src_used), .id_dst_addr(id_dst_addr), .id_dst_we(id_dst_we),
    .id_is_load(id_is_load), .id_is_mdu(id_is_mdu), .ex_jump(ex_jump),
    .ex_jump_r(ex_jump_r), .stall(stall), .bubble(bubble), .flush(flush),
    .busy_mask(busy_mask)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model kept as absolute times: the cycle number at which each
  // register becomes readable, at which the MDU becomes free, and until
  // which IF/ID is killed.
  int ready_at [NREG];
  int mdu_free;
  int flush_until;
  int cyc = 0;

  logic            e_stall, e_bubble, e_flush, e_issue;
  logic [NREG-1:0] e_busy;

  function automatic void model_reset();
    for (int r = 0; r < NREG; r++) ready_at[r] = 0;
    mdu_free    = 0;
    flush_until = 0;
  endfunction

  function automatic void model_eval();
    logic blocked;
    int   a;
    blocked = 1'b0;
    e_flush = ex_jump || ex_jump_r || (cyc < flush_until);
    for (int i = 0; i < NUM_SRC; i++) begin
      a = int'(id_src_addr[i*REG_ADDR_W +: REG_ADDR_W]);
      if (id_src_used[i] && a != 0 && cyc < ready_at[a]) blocked = 1'b1;
    end
    if (id_dst_we && id_dst_addr != 0 && cyc < ready_at[id_dst_addr]) blocked = 1'b1;
    if (id_is_mdu && cyc < mdu_free) blocked = 1'b1;
    e_stall  = id_valid && !e_flush && blocked;
    e_bubble = e_flush || e_stall;
    e_issue  = id_valid && !e_stall && !e_flush;
    for (int r = 0; r < NREG; r++) e_busy[r] = (cyc < ready_at[r]);
  endfunction

  function automatic void model_commit();
    int lat;
    if (e_issue && id_dst_we && id_dst_addr != 0) begin
      lat = id_is_load ? LOAD_LAT : (id_is_mdu ? MDU_LAT : 0);
      ready_at[id_dst_addr] = cyc + 1 + lat;
    end
    if (e_issue && id_is_mdu) mdu_free = cyc + 1 + MDU_LAT;
    if (ex_jump_r)    flush_until = cyc + FLUSH_JR;
    else if (ex_jump) flush_until = cyc + FLUSH_J;
    cyc++;
  endfunction

  task automatic set_instr(input bit v, input int s0, input bit u0, input int s1,
                           input bit u1, input int d, input bit we, input bit ld,
                           input bit md);
    id_valid    = v;
    id_src_addr = {REG_ADDR_W'(s1), REG_ADDR_W'(s0)};
    id_src_used = {u1, u0};
    id_dst_addr = REG_ADDR_W'(d);
    id_dst_we   = we;
    id_is_load  = ld;
    id_is_mdu   = md;
  endtask

  task automatic set_jump(input bit j, input bit jr);
    ex_jump   = j;
    ex_jump_r = jr;
  endtask

  task automatic pre();
    @(negedge clk);
    model_eval();
  endtask

  task automatic post();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic idle(input int n);
    set_instr(0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_jump(0, 0);
    repeat (n) begin pre(); post(); end
  endtask

  task automatic test_reset();
    pre();
    checks++; if ({stall, bubble, flush} !== 3'b000) begin failures++; $display("FAIL reset_outputs got sbf=%b want 000", {stall, bubble, flush}); end
    checks++; if (busy_mask !== '0) begin failures++; $display("FAIL reset_busy got %h want 0", busy_mask); end
    rstn = 1'b1;
    post();
  endtask

  task automatic test_load_use();
    idle(6);
    set_instr(1, 0, 0, 0, 0, 5, 1, 1, 0);
    pre();
    checks++; if ({stall, bubble, flush, busy_mask} !== {e_stall, e_bubble, e_flush, e_busy}) begin failures++; $display("FAIL load_issue cyc=%0d got sbf=%b busy=%h want sbf=%b busy=%h", cyc, {stall, bubble, flush}, busy_mask, {e_stall, e_bubble, e_flush}, e_busy); end
    post();
    set_instr(1, 5, 1, 0, 0, 6, 1, 0, 0);
    pre();
    checks++; if ({stall, bubble, flush, busy_mask} !== {e_stall, e_bubble, e_flush, e_busy}) begin failures++; $display("FAIL load_use_hold cyc=%0d got sbf=%b busy=%h want sbf=%b busy=%h", cyc, {stall, bubble, flush}, busy_mask, {e_stall, e_bubble, e_flush}, e_busy); end
    checks++; if ({stall, bubble, busy_mask[5]} !== 3'b111) begin failures++; $display("FAIL load_use_stall got stall,bubble,busy5=%b want 111", {stall, bubble, busy_mask[5]}); end
    post();
    pre();
    checks++; if ({stall, bubble, busy_mask[5]} !== 3'b000) begin failures++; $display("FAIL load_use_release got stall,bubble,busy5=%b want 000", {stall, bubble, busy_mask[5]}); end
    post();
  endtask

  task automatic test_mdu();
    idle(6);
    set_instr(1, 0, 0, 0, 0, 7, 1, 0, 1);
    pre(); post();
    set_instr(1, 0, 0, 0, 0, 7, 1, 0, 0);
    for (int k = 0; k < 5; k++) begin
      pre();
      checks++; if ({stall, bubble, flush, busy_mask} !== {e_stall, e_bubble, e_flush, e_busy}) begin failures++; $display("FAIL mdu_waw_model cyc=%0d got sbf=%b busy=%h want sbf=%b busy=%h", cyc, {stall, bubble, flush}, busy_mask, {e_stall, e_bubble, e_flush}, e_busy); end
      checks++; if (stall !== (k < 4)) begin failures++; $display("FAIL mdu_waw_stall k=%0d got %b want %b", k, stall, (k < 4)); end
      post();
    end
    idle(6);
    set_instr(1, 0, 0, 0, 0, 8, 1, 0, 1);
    pre(); post();
    set_instr(1, 0, 0, 0, 0, 9, 1, 0, 1);
    for (int k = 0; k < 5; k++) begin
      pre();
      checks++; if ({stall, bubble, flush, busy_mask} !== {e_stall, e_bubble, e_flush, e_busy}) begin failures++; $display("FAIL mdu_struct_model cyc=%0d got sbf=%b busy=%h want sbf=%b busy=%h", cyc, {stall, bubble, flush}, busy_mask, {e_stall, e_bubble, e_flush}, e_busy); end
      checks++; if (stall !== (k < 4)) begin failures++; $display("FAIL mdu_struct_stall k=%0d got %b want %b", k, stall, (k < 4)); end
      post();
    end
  endtask

  task automatic test_x0();
    idle(6);
    set_instr(1, 0, 0, 0, 0, 0, 1, 1, 0);
    pre(); post();
    set_instr(1, 0, 1, 0, 1, 0, 1, 0, 0);
    pre();
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL x0_no_stall got %b want 0", stall); end
    checks++; if (busy_mask !== '0) begin failures++; $display("FAIL x0_busy got %h want 0", busy_mask); end
    post();
  endtask

  task automatic test_flush();
    idle(6);
    set_instr(1, 1, 1, 2, 1, 3, 1, 0, 0);
    set_jump(0, 1);
    pre();
    checks++; if ({stall, bubble, flush} !== 3'b011) begin failures++; $display("FAIL flush_jr_c1 got sbf=%b want 011", {stall, bubble, flush}); end
    post();
    set_jump(1, 0);
    pre();
    checks++; if ({stall, bubble, flush} !== 3'b011) begin failures++; $display("FAIL flush_j_during got sbf=%b want 011", {stall, bubble, flush}); end
    post();
    set_jump(0, 0);
    pre();
    checks++; if ({stall, bubble, flush, busy_mask} !== {e_stall, e_bubble, e_flush, e_busy}) begin failures++; $display("FAIL flush_tail cyc=%0d got sbf=%b busy=%h want sbf=%b busy=%h", cyc, {stall, bubble, flush}, busy_mask, {e_stall, e_bubble, e_flush}, e_busy); end
    post();
    idle(3);
    set_jump(1, 0);
    pre();
    checks++; if (flush !== 1'b1) begin failures++; $display("FAIL flush_j_only got %b want 1", flush); end
    post();
    set_jump(0, 0);
    pre();
    checks++; if (flush !== 1'b0) begin failures++; $display("FAIL flush_j_len got %b want 0", flush); end
    post();
  endtask

  task automatic test_both_redirect();
    idle(6);
    set_instr(1, 0, 0, 0, 0, 4, 1, 0, 1);
    pre(); post();
    set_instr(1, 4, 1, 0, 0, 10, 1, 0, 0);
    set_jump(1, 1);
    pre();
    checks++; if ({stall, bubble, flush} !== 3'b011) begin failures++; $display("FAIL both_c1 got sbf=%b want 011", {stall, bubble, flush}); end
    post();
    set_jump(0, 0);
    pre();
    checks++; if ({stall, bubble, flush} !== 3'b011) begin failures++; $display("FAIL both_c2 got sbf=%b want 011", {stall, bubble, flush}); end
    post();
    pre();
    checks++; if ({stall, bubble, flush} !== 3'b110) begin failures++; $display("FAIL both_c3 got sbf=%b want 110", {stall, bubble, flush}); end
    post();
  endtask

  task automatic test_reset_mid();
    idle(6);
    set_instr(1, 0, 0, 0, 0, 3, 1, 0, 1);
    pre(); post();
    set_instr(0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_jump(0, 1);
    pre(); post();
    set_jump(0, 0);
    #1;
    checks++; if ({busy_mask[3], flush} !== 2'b11) begin failures++; $display("FAIL rst_mid_pre got busy3,flush=%b want 11", {busy_mask[3], flush}); end
    rstn = 1'b0;
    #1;
    model_reset();
    checks++; if (busy_mask !== '0) begin failures++; $display("FAIL rst_mid_busy got %h want 0", busy_mask); end
    checks++; if ({stall, bubble, flush} !== 3'b000) begin failures++; $display("FAIL rst_mid_out got sbf=%b want 000", {stall, bubble, flush}); end
    @(negedge clk);
    model_eval();
    rstn = 1'b1;
    post();
    set_instr(1, 3, 1, 0, 0, 11, 1, 0, 0);
    pre();
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL rst_mid_reader got stall=%b want 0", stall); end
    checks++; if ({stall, bubble, flush, busy_mask} !== {e_stall, e_bubble, e_flush, e_busy}) begin failures++; $display("FAIL rst_mid_model cyc=%0d got sbf=%b busy=%h want sbf=%b busy=%h", cyc, {stall, bubble, flush}, busy_mask, {e_stall, e_bubble, e_flush}, e_busy); end
    post();
  endtask

  task automatic test_random();
    int kind;
    idle(6);
    for (int n = 0; n < 800; n++) begin
      kind = int'($urandom_range(0, 2));
      set_instr(($urandom_range(0, 9) < 8), int'($urandom_range(0, 7)), 1'($urandom),
                int'($urandom_range(0, 7)), 1'($urandom), int'($urandom_range(0, 7)),
                ($urandom_range(0, 3) != 0), (kind == 1), (kind == 2));
      set_jump(($urandom_range(0, 19) == 0), ($urandom_range(0, 19) == 0));
      pre();
      checks++; if ({stall, bubble, flush, busy_mask} !== {e_stall, e_bubble, e_flush, e_busy}) begin failures++; $display("FAIL random cyc=%0d got sbf=%b busy=%h want sbf=%b busy=%h", cyc, {stall, bubble, flush}, busy_mask, {e_stall, e_bubble, e_flush}, e_busy); end
      post();
    end
  endtask

  initial begin
    rstn = 1'b0;
    set_instr(0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_jump(0, 0);
    model_reset();
    test_reset();
    test_load_use();
    test_mdu();
    test_x0();
    test_flush();
    test_both_redirect();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
